// File: rtl/fetch_pkg.sv
// Shared constants and helpers for the instruction-fetch front end.
package fetch_pkg;

  localparam int unsigned INSTR_W  = 32;
  localparam int unsigned PC_STEP  = 4;
  // Widest PC the helpers handle; callers cast to their own XLEN.
  localparam int unsigned MAX_XLEN = 64;

  // Clear the two low address bits so every fetch is word aligned.
  function automatic logic [MAX_XLEN-1:0] align4(input logic [MAX_XLEN-1:0] pc);
    return {pc[MAX_XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO: DEPTH entries, head visible combinationally, flush clears it.
module fetch_fifo #(
  parameter  int DEPTH = 4,
  parameter  int W     = 64,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  input  logic          flush,
  output logic [CW-1:0] count,
  output logic [W-1:0]  head
);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;

  // Storage write; entries need no reset because count gates their visibility.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointer and occupancy update; flush wins over any push/pop in the same cycle.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1'b1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1'b1);
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_prefetch_unit.sv
// Instruction-fetch front end: owns the fetch PC, issues credit-limited
// in-order requests, buffers responses tagged with their PC and handles
// redirects by flushing the buffer and dropping in-flight (stale) words.
module fetch_prefetch_unit
  import fetch_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               n_rst,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [XLEN-1:0]    imem_req_addr,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  input  logic               redirect_valid,
  input  logic [XLEN-1:0]    redirect_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr,
  output logic [XLEN-1:0]    instr_pc
);

  localparam int              CW   = $clog2(DEPTH + 1);
  localparam int              EW   = INSTR_W + XLEN;
  localparam logic [CW:0]     CAP  = (CW + 1)'(DEPTH);
  localparam logic [XLEN-1:0] STEP = XLEN'(PC_STEP);

  // One buffered word together with the address it was fetched from.
  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [XLEN-1:0]    pc;
  } fetch_entry_t;

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] rsp_pc;
  logic [XLEN-1:0] redirect_target;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   stale;
  logic [CW-1:0]   count;
  logic            has_credit;
  logic            accept;
  logic            push;
  logic            pop;
  fetch_entry_t    push_entry;
  fetch_entry_t    head_entry;
  logic [EW-1:0]   head_bits;

  assign redirect_target = XLEN'(align4(MAX_XLEN'(redirect_pc)));

  // Buffered plus in-flight words (stale ones included) may never exceed DEPTH,
  // so every accepted request already owns a FIFO slot.
  assign has_credit     = ({1'b0, count} + {1'b0, outstanding}) < CAP;
  assign imem_req_valid = n_rst && !redirect_valid && has_credit;
  assign imem_req_addr  = fetch_pc;
  assign accept         = imem_req_valid && imem_req_ready;

  // Responses during a redirect or while stale words remain are wrong-path.
  assign push = imem_rsp_valid && !redirect_valid && (stale == '0);
  assign pop  = instr_valid && instr_ready;

  assign push_entry.instr = imem_rsp_data;
  assign push_entry.pc    = rsp_pc;
  assign head_entry       = fetch_entry_t'(head_bits);

  assign instr_valid = (count != '0);
  assign instr       = instr_valid ? head_entry.instr : '0;
  assign instr_pc    = instr_valid ? head_entry.pc : RESET_PC;

  // Fetch PC: a redirect reloads it, an accepted request advances it.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      fetch_pc <= RESET_PC;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_target;
    end else if (accept) begin
      fetch_pc <= fetch_pc + STEP;
    end
  end

  // PC tag for the next kept response; follows the fetch PC after a redirect.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rsp_pc <= RESET_PC;
    end else if (redirect_valid) begin
      rsp_pc <= redirect_target;
    end else if (push) begin
      rsp_pc <= rsp_pc + STEP;
    end
  end

  // In-flight and stale bookkeeping; a redirect marks everything still in flight stale.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      outstanding <= '0;
      stale       <= '0;
    end else begin
      outstanding <= outstanding + CW'(accept) - CW'(imem_rsp_valid);
      if (redirect_valid) begin
        stale <= outstanding - CW'(imem_rsp_valid);
      end else if (imem_rsp_valid && (stale != '0)) begin
        stale <= stale - CW'(1'b1);
      end
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_fifo (
    .clk       (clk),
    .n_rst     (n_rst),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .flush     (redirect_valid),
    .count     (count),
    .head      (head_bits)
  );

endmodule
